// File: rtl/sram_arb_pkg.sv
// sram_arbiter shared types and default timing.
// SRAM_ARB_STARVE_GUARD_EN enables the read starvation guard.
package sram_arb_pkg;

    localparam int SRAM_DW = 32;
    localparam int HALF_DW = 16;
    localparam int CNT_W   = 8;

    typedef struct packed {
        int unsigned we_cycles;
        int unsigned rd_cycles;
    } sram_timing_t;

    // 20 ns MCLK against a 55 ns SRAM
    localparam sram_timing_t DEF_TIMING = '{we_cycles: 2, rd_cycles: 3};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR_SETUP  = 3'd1,
        ST_WR_STROBE = 3'd2,
        ST_WR_HOLD   = 3'd3,
        ST_RD_ACCESS = 3'd4,
        ST_RD_DONE   = 3'd5
    } arb_state_e;

    // Timer load value for an interval of n cycles (terminal count at 0)
    function automatic logic [CNT_W-1:0] cnt_load(input int n);
        if (n <= 1) return '0;
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/sram_arb_if.sv
// Requester and SRAM-pin bundle for sram_arbiter.
// slave = arbiter side, master = requesters/pads side.
interface sram_arb_if #(
    parameter int ADDR_W = 18
);
    import sram_arb_pkg::*;

    logic                wr_req;
    logic [ADDR_W-1:0]   wr_addr;
    logic [SRAM_DW-1:0]  wr_data;
    logic                wr_ack;
    logic                rd_req;
    logic [ADDR_W-1:0]   rd_addr;
    logic [SRAM_DW-1:0]  rd_data;
    logic                rd_ack;
    logic [ADDR_W-1:0]   sram_addr;
    logic                sram_ce1_n;
    logic                sram_ce2_n;
    logic                sram_ub_n;
    logic                sram_lb_n;
    logic                sram_we_n;
    logic                sram_oe_n;
    logic [SRAM_DW-1:0]  data_out;
    logic                data_oe;
    logic [SRAM_DW-1:0]  data_in;
    logic                busy;

    modport slave (
        input  wr_req, wr_addr, wr_data,
        input  rd_req, rd_addr, data_in,
        output wr_ack, rd_data, rd_ack,
        output sram_addr, sram_ce1_n, sram_ce2_n,
        output sram_ub_n, sram_lb_n, sram_we_n, sram_oe_n,
        output data_out, data_oe, busy
    );

    modport master (
        output wr_req, wr_addr, wr_data,
        output rd_req, rd_addr, data_in,
        input  wr_ack, rd_data, rd_ack,
        input  sram_addr, sram_ce1_n, sram_ce2_n,
        input  sram_ub_n, sram_lb_n, sram_we_n, sram_oe_n,
        input  data_out, data_oe, busy
    );

endinterface

// File: rtl/sram_access_timer.sv
// Loadable down-counter with terminal-count flag.
// Shared by the write-strobe and read-access intervals.
module sram_access_timer
    import sram_arb_pkg::*;
(
    input  logic             MCLK,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_count;

    // Load has priority; decrement saturates at zero
    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n)
            r_count <= '0;
        else if (i_load)
            r_count <= i_load_val;
        else if (i_dec && r_count != '0)
            r_count <= r_count - 1'b1;
    end

    assign o_tc = (r_count == '0);

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester async SRAM arbiter and strobe sequencer.
// SRAM_ARB_STARVE_GUARD_EN: force a pending read after MAX_WR_RUN writes.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W     = 18,
    parameter int WE_CYCLES  = DEF_TIMING.we_cycles,
    parameter int RD_CYCLES  = DEF_TIMING.rd_cycles,
    parameter int MAX_WR_RUN = 16
) (
    input  logic     MCLK,
    input  logic     reset_n,
    sram_arb_if.slave bus
);

`ifdef SRAM_ARB_STARVE_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    logic [ADDR_W-1:0]  r_addr;
    logic [SRAM_DW-1:0] r_wdata;
    logic [SRAM_DW-1:0] r_rd_data;
    logic [4:0]         r_wr_run;

    logic               w_load;
    logic [CNT_W-1:0]   w_load_val;
    logic               w_dec;
    logic               w_tc;
    logic               w_wr_grant;
    logic               w_rd_grant;
    logic               w_capture;
    logic               w_guard;
    logic               w_wr_phase;
    logic               w_access;

    assign w_guard = GUARD_EN && (int'(r_wr_run) >= MAX_WR_RUN);

    // Next-state, grant and timer control
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_dec       = 1'b0;
        w_wr_grant  = 1'b0;
        w_rd_grant  = 1'b0;
        w_capture   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.rd_req && (!bus.wr_req || w_guard)) begin
                    w_rd_grant  = 1'b1;
                    w_load      = 1'b1;
                    w_load_val  = cnt_load(RD_CYCLES);
                    w_state_nxt = ST_RD_ACCESS;
                end else if (bus.wr_req) begin
                    w_wr_grant  = 1'b1;
                    w_state_nxt = ST_WR_SETUP;
                end
            end
            ST_WR_SETUP: begin
                w_load      = 1'b1;
                w_load_val  = cnt_load(WE_CYCLES);
                w_state_nxt = ST_WR_STROBE;
            end
            ST_WR_STROBE: begin
                if (w_tc) w_state_nxt = ST_WR_HOLD;
                else      w_dec       = 1'b1;
            end
            ST_WR_HOLD: w_state_nxt = ST_IDLE;
            ST_RD_ACCESS: begin
                if (w_tc) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RD_DONE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_RD_DONE: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    sram_access_timer u_timer (
        .MCLK       (MCLK),
        .reset_n    (reset_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_tc       (w_tc)
    );

    // State register
    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Latch address and write data on grant
    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_wr_grant) begin
            r_addr  <= bus.wr_addr;
            r_wdata <= bus.wr_data;
        end else if (w_rd_grant) begin
            r_addr  <= bus.rd_addr;
        end
    end

    // Sample pad data on the last access cycle; hold until next read
    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n)       r_rd_data <= '0;
        else if (w_capture) r_rd_data <= bus.data_in;
    end

    // Consecutive write-grant run length, saturating
    always_ff @(posedge MCLK or negedge reset_n) begin
        if (!reset_n)
            r_wr_run <= '0;
        else if (w_rd_grant)
            r_wr_run <= '0;
        else if (w_wr_grant && r_wr_run != 5'h1f)
            r_wr_run <= r_wr_run + 5'd1;
    end

    assign w_wr_phase = (r_state == ST_WR_SETUP)
                     || (r_state == ST_WR_STROBE)
                     || (r_state == ST_WR_HOLD);
    assign w_access   = w_wr_phase || (r_state == ST_RD_ACCESS);

    assign bus.sram_ce1_n = !w_access;
    assign bus.sram_ce2_n = !w_access;
    assign bus.sram_ub_n  = !w_access;
    assign bus.sram_lb_n  = !w_access;
    assign bus.sram_we_n  = !(r_state == ST_WR_STROBE);
    assign bus.sram_oe_n  = !(r_state == ST_RD_ACCESS);
    assign bus.data_oe    = w_wr_phase;
    assign bus.wr_ack     = (r_state == ST_WR_HOLD);
    assign bus.rd_ack     = (r_state == ST_RD_DONE);
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.sram_addr  = r_addr;
    assign bus.data_out   = {r_wdata[SRAM_DW-1:HALF_DW],
                             r_wdata[HALF_DW-1:0]};
    assign bus.rd_data    = r_rd_data;

endmodule
